// File: rtl/syn_exec_controller.sv
// Run/step/breakpoint sequencer gating the single-cycle core's enable,
// with saturating execution statistics for the display path.
module syn_exec_controller #(
   parameter int CntWidth = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                run_req,
   input  logic                step_req,
   input  logic                bp_en,
   input  logic [31:0]         bp_addr,
   input  logic [31:0]         pc_dbg,
   input  logic                halt,
   input  logic                jumped,
   input  logic                is_branch,
   input  logic                branched,
   output logic                cpu_en,
   output logic [1:0]          state,
   output logic                bp_hit,
   output logic [CntWidth-1:0] inst_cnt,
   output logic [CntWidth-1:0] jump_cnt,
   output logic [CntWidth-1:0] branch_cnt,
   output logic [CntWidth-1:0] taken_cnt
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      STEP   = 2'd2,
      HALTED = 2'd3
   } state_t;

   state_t state_q;
   logic   step_q;
   logic   bp_skip;
   logic   step_rise;
   logic   bp_match;

   function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] cnt,
                                                   input logic inc);
      if (inc && (cnt != {CntWidth{1'b1}}))
         return cnt + CntWidth'(1);
      return cnt;
   endfunction

   assign state     = state_q;
   assign step_rise = step_req & ~step_q;
   // bp_skip masks the match so a run can resume from the breakpoint address.
   assign bp_match  = bp_en & (pc_dbg == bp_addr) & ~bp_skip;

   // Combinational so run_req drop, halt and breakpoint all gate this same cycle.
   always_comb begin
      cpu_en = 1'b0;
      case (state_q)
         STEP:    cpu_en = ~halt;
         RUN:     cpu_en = run_req & ~halt & ~bp_match;
         default: cpu_en = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         step_q     <= 1'b0;
         bp_skip    <= 1'b0;
         bp_hit     <= 1'b0;
         inst_cnt   <= '0;
         jump_cnt   <= '0;
         branch_cnt <= '0;
         taken_cnt  <= '0;
      end else begin
         step_q <= step_req;

         if (cpu_en) begin
            inst_cnt   <= sat_inc(inst_cnt, 1'b1);
            jump_cnt   <= sat_inc(jump_cnt, jumped);
            branch_cnt <= sat_inc(branch_cnt, is_branch);
            taken_cnt  <= sat_inc(taken_cnt, branched);
            bp_skip    <= 1'b0;
            bp_hit     <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (halt) begin
                  state_q <= HALTED;
               end else if (step_rise) begin
                  state_q <= STEP;
               end else if (run_req) begin
                  state_q <= RUN;
                  bp_skip <= 1'b1;
               end
            end
            STEP: state_q <= IDLE;
            RUN: begin
               if (halt) begin
                  state_q <= HALTED;
               end else if (bp_match) begin
                  state_q <= IDLE;
                  bp_hit  <= 1'b1;
               end else if (!run_req) begin
                  state_q <= IDLE;
               end
            end
            HALTED:  state_q <= HALTED;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_syn_exec_controller.sv
// Directed bench for syn_exec_controller: run, step, breakpoint, statistics,
// halt, asynchronous reset and counter saturation (second instance, CntWidth=4).
module tb_syn_exec_controller;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        run_req, step_req, bp_en, halt, jumped, is_branch, branched;
   logic [31:0] bp_addr, pc_dbg;
   logic        cpu_en, bp_hit;
   logic [1:0]  state;
   logic [31:0] inst_cnt, jump_cnt, branch_cnt, taken_cnt;
   logic        cpu_en4, bp_hit4;
   logic [1:0]  state4;
   logic [3:0]  inst_cnt4, jump_cnt4, branch_cnt4, taken_cnt4;

   int          n_vec = 0;
   int          n_err = 0;
   logic        en_s;
   logic [1:0]  st_s;

   always #5 clk = ~clk;

   syn_exec_controller dut (
      .clk(clk), .rst_n(rst_n), .run_req(run_req), .step_req(step_req),
      .bp_en(bp_en), .bp_addr(bp_addr), .pc_dbg(pc_dbg), .halt(halt),
      .jumped(jumped), .is_branch(is_branch), .branched(branched),
      .cpu_en(cpu_en), .state(state), .bp_hit(bp_hit),
      .inst_cnt(inst_cnt), .jump_cnt(jump_cnt), .branch_cnt(branch_cnt),
      .taken_cnt(taken_cnt)
   );

   syn_exec_controller #(.CntWidth(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .run_req(run_req), .step_req(step_req),
      .bp_en(bp_en), .bp_addr(bp_addr), .pc_dbg(pc_dbg), .halt(halt),
      .jumped(jumped), .is_branch(is_branch), .branched(branched),
      .cpu_en(cpu_en4), .state(state4), .bp_hit(bp_hit4),
      .inst_cnt(inst_cnt4), .jump_cnt(jump_cnt4), .branch_cnt(branch_cnt4),
      .taken_cnt(taken_cnt4)
   );

   // Minimal core model: PC advances one word per enabled cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      pc_dbg <= 32'd0;
      else if (cpu_en) pc_dbg <= pc_dbg + 32'd4;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge with inputs already set: samples the cycle, returns at next negedge.
   task automatic tick();
      #1;
      en_s = cpu_en;
      st_s = state;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      run_req = 0; step_req = 0; halt = 0;
      jumped = 0; is_branch = 0; branched = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int          en_cnt;
      logic [19:0] st_got, st_exp;
      logic [9:0]  en_got, en_exp;
      logic [9:0]  step_pat;
      logic [7:0]  sr_st_got, sr_st_exp;
      logic [3:0]  sr_en_got;
      int          exp_st[10] = '{0, 2, 0, 0, 0, 0, 0, 0, 2, 0};

      bp_en = 1'b0;
      bp_addr = 32'h0000_0010;
      rst_n = 1'b0;
      run_req = 0; step_req = 0; halt = 0;
      jumped = 0; is_branch = 0; branched = 0;
      repeat (2) @(negedge clk);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_cpu_en", 32'(cpu_en), 32'd0);
      chk("rst_bp_hit", 32'(bp_hit), 32'd0);
      chk("rst_inst_cnt", inst_cnt, 32'd0);
      rst_n = 1'b1;

      // Free run: one IDLE cycle, then 10 enabled cycles.
      run_req = 1'b1;
      en_cnt = 0;
      for (int i = 0; i < 11; i++) begin
         tick();
         en_cnt += int'(en_s);
      end
      chk("run_en_cycles", 32'(en_cnt), 32'd10);
      run_req = 1'b0;
      #1;
      chk("run_drop_en", 32'(cpu_en), 32'd0);
      chk("run_drop_state", 32'(state), 32'd1);
      @(negedge clk);
      chk("run_end_state", 32'(state), 32'd0);
      chk("run_inst_cnt", inst_cnt, 32'd10);

      // Step: held high 5, low 2, high 3 -> two single-cycle pulses.
      step_pat = 10'b11_1001_1111;
      for (int i = 0; i < 10; i++) begin
         step_req = step_pat[i];
         tick();
         st_got[2*i +: 2] = st_s;
         en_got[i] = en_s;
         st_exp[2*i +: 2] = 2'(exp_st[i]);
         en_exp[i] = (exp_st[i] == 2);
      end
      chk("step_state_seq", 32'(st_got), 32'(st_exp));
      chk("step_en_seq", 32'(en_got), 32'(en_exp));
      step_req = 1'b0;
      tick();
      chk("step_inst_cnt", inst_cnt, 32'd12);

      // Simultaneous step_rise and run_req: STEP first, then RUN.
      step_req = 1'b1;
      run_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         sr_st_got[2*i +: 2] = st_s;
         sr_en_got[i] = en_s;
      end
      sr_st_exp = {2'd1, 2'd0, 2'd2, 2'd0};
      chk("step_run_states", 32'(sr_st_got), 32'(sr_st_exp));
      chk("step_run_en", 32'(sr_en_got), 32'b1010);
      run_req = 1'b0;
      step_req = 1'b0;
      tick();
      tick();

      // Breakpoint at 0x10, then resume past it.
      do_reset();
      bp_en = 1'b1;
      run_req = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      chk("bp_stop_en", 32'(en_s), 32'd0);
      run_req = 1'b0;
      #1;
      chk("bp_stop_state", 32'(state), 32'd0);
      chk("bp_hit_set", 32'(bp_hit), 32'd1);
      chk("bp_stop_pc", pc_dbg, 32'h10);
      chk("bp_stop_inst", inst_cnt, 32'd4);
      tick();
      run_req = 1'b1;
      tick();
      #1;
      chk("bp_resume_en", 32'(cpu_en), 32'd1);
      chk("bp_hit_held", 32'(bp_hit), 32'd1);
      tick();
      chk("bp_hit_clear", 32'(bp_hit), 32'd0);
      chk("bp_resume_pc", pc_dbg, 32'h14);
      chk("bp_resume_inst", inst_cnt, 32'd5);
      run_req = 1'b0;
      tick();
      bp_en = 1'b0;

      // Statistics: 12 enabled cycles with patterned flags.
      do_reset();
      run_req = 1'b1;
      tick();
      for (int i = 0; i < 12; i++) begin
         jumped    = (i % 3 == 2);
         is_branch = (i % 2 == 0);
         branched  = (i % 2 == 0);
         tick();
      end
      run_req = 0; jumped = 0; is_branch = 0; branched = 0;
      tick();
      chk("stat_inst", inst_cnt, 32'd12);
      chk("stat_jump", jump_cnt, 32'd4);
      chk("stat_branch", branch_cnt, 32'd6);
      chk("stat_taken", taken_cnt, 32'd6);

      // Halt during RUN: absorbing until reset.
      do_reset();
      run_req = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      halt = 1'b1;
      #1;
      chk("halt_en_drop", 32'(cpu_en), 32'd0);
      chk("halt_state_run", 32'(state), 32'd1);
      tick();
      chk("halt_state", 32'(state), 32'd3);
      chk("halt_inst", inst_cnt, 32'd3);
      halt = 1'b0;
      en_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         step_req = i[0];
         tick();
         en_cnt += int'(en_s);
      end
      chk("halt_no_en", 32'(en_cnt), 32'd0);
      chk("halt_absorb", 32'(state), 32'd3);
      chk("halt_inst_frozen", inst_cnt, 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("halt_rst_state", 32'(state), 32'd0);
      chk("halt_rst_inst", inst_cnt, 32'd0);
      @(negedge clk);
      run_req = 0; step_req = 0;
      rst_n = 1'b1;

      // Saturation on the narrow instance, then asynchronous reset mid-run.
      run_req = 1'b1;
      for (int i = 0; i < 21; i++) tick();
      chk("sat_inst4", 32'(inst_cnt4), 32'd15);
      chk("sat_inst32", inst_cnt, 32'd20);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_en", 32'(cpu_en), 32'd0);
      chk("arst_state", 32'(state), 32'd0);
      chk("arst_inst", inst_cnt, 32'd0);
      chk("arst_inst4", 32'(inst_cnt4), 32'd0);
      @(negedge clk);
      run_req = 1'b0;
      rst_n = 1'b1;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
